// File: rtl/robinho_ctrl_v2.sv
// robinho_ctrl_v2: pick-up robot controller (search, approach, timed claw down/close/up/release).
// Latency: sensor pins reach the FSM after SYNC_STAGES flops; outputs are Moore-decoded from state, c_close registered.
// Backpressure: none; once the claw sequence starts it always runs to completion.
// Optional feature macro: ROBINHO_SEARCH_TIMEOUT_EN (escape counter + sticky search_fail).
module robinho_ctrl_v2 #(
  parameter int TW              = 24,
  parameter int T_CLAW_OPEN     = 1000000,
  parameter int T_CLAW_DOWN     = 1000000,
  parameter int T_CLAW_CLOSE    = 1000000,
  parameter int T_CLAW_UP       = 1000000,
  parameter int T_STEP          = 250000,
  parameter int MAX_TURNS       = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_AFTER_PICK = 0,
  parameter int PCW             = 8,
  parameter int MAX_ESCAPES     = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rasp_on,
  input  logic           obj_in_sight,
  input  logic           obj_is_close,
  output logic [3:0]     w_motor,
  output logic [1:0]     c_motor,
  output logic           c_close,
  output logic [2:0]     state_o,
  output logic [PCW-1:0] pick_count,
  output logic           search_fail
);

  typedef enum logic [2:0] {
    S_CLAW_OPEN  = 3'd0,
    S_IDLE       = 3'd1,
    S_STOP       = 3'd2,
    S_FORWARD    = 3'd3,
    S_TURN       = 3'd4,
    S_CLAW_DOWN  = 3'd5,
    S_CLAW_CLOSE = 3'd6,
    S_CLAW_UP    = 3'd7
  } state_t;

  localparam int TCW = (MAX_TURNS > 1) ? $clog2(MAX_TURNS) : 1;
  localparam logic [TW-1:0]  END_OPEN  = TW'(T_CLAW_OPEN - 1);
  localparam logic [TW-1:0]  END_DOWN  = TW'(T_CLAW_DOWN - 1);
  localparam logic [TW-1:0]  END_CLOSE = TW'(T_CLAW_CLOSE - 1);
  localparam logic [TW-1:0]  END_UP    = TW'(T_CLAW_UP - 1);
  localparam logic [TW-1:0]  END_STEP  = TW'(T_STEP - 1);
  localparam logic [TCW-1:0] LAST_TURN = TCW'(MAX_TURNS - 1);

  state_t                 state, state_nxt;
  logic [TW-1:0]          timer;
  logic [TCW-1:0]         turn_cnt, turn_nxt;
  logic                   restart, enter, pick_done;
  logic                   escape, obj_exit, esc_limit;
  logic [SYNC_STAGES-1:0] rasp_sync, sight_sync, close_sync;
  logic                   rasp_s, sight_s, close_s;

  // sensor pin synchronisers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rasp_sync  <= '0;
      sight_sync <= '0;
      close_sync <= '0;
    end else begin
      rasp_sync  <= {rasp_sync[SYNC_STAGES-2:0], rasp_on};
      sight_sync <= {sight_sync[SYNC_STAGES-2:0], obj_in_sight};
      close_sync <= {close_sync[SYNC_STAGES-2:0], obj_is_close};
    end
  end

  assign rasp_s  = rasp_sync[SYNC_STAGES-1];
  assign sight_s = sight_sync[SYNC_STAGES-1];
  assign close_s = close_sync[SYNC_STAGES-1];

  // next state, slice restarts, turn counter and event strobes
  always_comb begin
    state_nxt = state;
    turn_nxt  = turn_cnt;
    restart   = 1'b0;
    pick_done = 1'b0;
    escape    = 1'b0;
    obj_exit  = 1'b0;
    case (state)
      S_CLAW_OPEN: if (timer == END_OPEN) state_nxt = S_IDLE;
      S_IDLE:      if (rasp_s && !search_fail) state_nxt = S_STOP;
      S_STOP: begin
        if (!rasp_s) state_nxt = S_IDLE;
        else if (close_s) begin state_nxt = S_CLAW_DOWN; obj_exit = 1'b1; end
        else if (sight_s) begin state_nxt = S_FORWARD; obj_exit = 1'b1; end
        else state_nxt = S_TURN;
      end
      S_FORWARD: begin
        if (!rasp_s) state_nxt = S_IDLE;
        else if (close_s) begin state_nxt = S_STOP; obj_exit = 1'b1; end
        else if (timer == END_STEP) begin
          if (sight_s) restart = 1'b1;
          else begin state_nxt = S_TURN; turn_nxt = '0; end
        end
      end
      S_TURN: begin
        if (!rasp_s) state_nxt = S_IDLE;
        else if (sight_s || close_s) begin
          state_nxt = S_STOP;
          turn_nxt  = '0;
          obj_exit  = 1'b1;
        end else if (timer == END_STEP) begin
          if (turn_cnt == LAST_TURN) begin
            escape    = 1'b1;
            turn_nxt  = '0;
            state_nxt = esc_limit ? S_IDLE : S_FORWARD;
          end else begin
            restart  = 1'b1;
            turn_nxt = turn_cnt + TCW'(1);
          end
        end
      end
      S_CLAW_DOWN:  if (timer == END_DOWN) state_nxt = S_CLAW_CLOSE;
      S_CLAW_CLOSE: if (timer == END_CLOSE) state_nxt = S_CLAW_UP;
      S_CLAW_UP: begin
        if (timer == END_UP) begin
          pick_done = 1'b1;
          state_nxt = (HOLD_AFTER_PICK != 0) ? S_STOP : S_CLAW_OPEN;
        end
      end
    endcase
    if (state_nxt == S_IDLE && state != S_IDLE) turn_nxt = '0;
  end

  assign enter = (state_nxt != state) || restart;

  // state register and dwell timer (cleared on every entry, saturating)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_CLAW_OPEN;
      timer    <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_nxt;
      turn_cnt <= turn_nxt;
      if (enter) timer <= '0;
      else if (timer != '1) timer <= timer + TW'(1);
    end
  end

  // gripper register and saturating pick counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_close    <= 1'b0;
      pick_count <= '0;
    end else begin
      if (enter && state_nxt == S_CLAW_CLOSE) c_close <= 1'b1;
      else if (enter && state_nxt == S_CLAW_OPEN) c_close <= 1'b0;
      if (pick_done && pick_count != '1) pick_count <= pick_count + PCW'(1);
    end
  end

`ifdef ROBINHO_SEARCH_TIMEOUT_EN
  localparam int ECW = $clog2(MAX_ESCAPES + 1);
  localparam logic [ECW-1:0] LAST_ESC = ECW'(MAX_ESCAPES - 1);
  logic [ECW-1:0] esc_cnt;

  assign esc_limit = (esc_cnt == LAST_ESC);

  // consecutive-escape counter and sticky search-timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      esc_cnt     <= '0;
      search_fail <= 1'b0;
    end else begin
      if (obj_exit || (escape && esc_limit)) esc_cnt <= '0;
      else if (escape) esc_cnt <= esc_cnt + ECW'(1);
      if (state == S_IDLE && !rasp_s) search_fail <= 1'b0;
      else if (escape && esc_limit) search_fail <= 1'b1;
    end
  end
`else
  localparam int unused_max_escapes = MAX_ESCAPES;
  logic unused_strobes;
  assign unused_strobes = escape ^ obj_exit;
  assign esc_limit      = 1'b0;
  assign search_fail    = 1'b0;
`endif

  // Moore output decode
  always_comb begin
    w_motor = 4'b0000;
    c_motor = 2'b00;
    case (state)
      S_FORWARD:   w_motor = 4'b0101;
      S_TURN:      w_motor = 4'b1001;
      S_CLAW_DOWN: c_motor = 2'b10;
      S_CLAW_UP:   c_motor = 2'b01;
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_robinho_ctrl_v2.sv
// Bench for robinho_ctrl_v2: scripted vector table plus hand-written pick/saturation/reset sequences.
// d0 releases after each pick (PCW=8); d1 holds after pick with a 2-bit counter.
module tb_robinho_ctrl_v2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rasp_on = 1'b0, obj_in_sight = 1'b0, obj_is_close = 1'b0;

  logic [3:0] w0, w1;
  logic [1:0] cm0, cm1;
  logic       cc0, cc1, sf0, sf1;
  logic [2:0] st0, st1;
  logic [7:0] pk0;
  logic [1:0] pk1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  robinho_ctrl_v2 #(
    .TW(24), .T_CLAW_OPEN(10), .T_CLAW_DOWN(10), .T_CLAW_CLOSE(10), .T_CLAW_UP(10),
    .T_STEP(8), .MAX_TURNS(4), .SYNC_STAGES(2), .HOLD_AFTER_PICK(0), .PCW(8), .MAX_ESCAPES(2)
  ) d0 (
    .clk(clk), .rst(rst), .rasp_on(rasp_on), .obj_in_sight(obj_in_sight), .obj_is_close(obj_is_close),
    .w_motor(w0), .c_motor(cm0), .c_close(cc0), .state_o(st0), .pick_count(pk0), .search_fail(sf0)
  );

  robinho_ctrl_v2 #(
    .TW(24), .T_CLAW_OPEN(10), .T_CLAW_DOWN(10), .T_CLAW_CLOSE(10), .T_CLAW_UP(10),
    .T_STEP(8), .MAX_TURNS(4), .SYNC_STAGES(2), .HOLD_AFTER_PICK(1), .PCW(2), .MAX_ESCAPES(2)
  ) d1 (
    .clk(clk), .rst(rst), .rasp_on(rasp_on), .obj_in_sight(obj_in_sight), .obj_is_close(obj_is_close),
    .w_motor(w1), .c_motor(cm1), .c_close(cc1), .state_o(st1), .pick_count(pk1), .search_fail(sf1)
  );

  typedef struct {
    logic       r, s, c;
    int         steps;
    logic [2:0] st;
    logic [3:0] w;
    logic [1:0] cm;
    logic       cc;
    logic [7:0] pk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic c, input int steps,
                     input logic [2:0] st, input logic [3:0] w, input logic [1:0] cm,
                     input logic cc, input logic [7:0] pk);
    vec_t v;
    v.r = r; v.s = s; v.c = c; v.steps = steps;
    v.st = st; v.w = w; v.cm = cm; v.cc = cc; v.pk = pk;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // inputs r,s,c held for 'steps' edges; expected state,w_motor,c_motor,c_close,pick_count after
    add(0,0,0, 9, 3'd0, 4'b0000, 2'b00, 0, 0);  // CLAW_OPEN dwell
    add(0,0,0, 1, 3'd1, 4'b0000, 2'b00, 0, 0);  // -> IDLE after 10
    add(0,0,0, 5, 3'd1, 4'b0000, 2'b00, 0, 0);
    add(1,0,0, 2, 3'd1, 4'b0000, 2'b00, 0, 0);  // rasp still in synchroniser
    add(1,0,0, 1, 3'd2, 4'b0000, 2'b00, 0, 0);  // STOP 3 edges later
    add(1,0,0, 1, 3'd4, 4'b1001, 2'b00, 0, 0);  // TURN
    add(1,0,0,31, 3'd4, 4'b1001, 2'b00, 0, 0);
    add(1,0,0, 1, 3'd3, 4'b0101, 2'b00, 0, 0);  // escape after 32
    add(1,1,0, 8, 3'd3, 4'b0101, 2'b00, 0, 0);  // slice restart with sight
    add(1,1,0, 2, 3'd3, 4'b0101, 2'b00, 0, 0);
    add(1,0,0, 3, 3'd3, 4'b0101, 2'b00, 0, 0);  // 3-cycle sight drop mid-slice
    add(1,1,0, 3, 3'd3, 4'b0101, 2'b00, 0, 0);  // still FORWARD at slice end
    add(1,0,0, 7, 3'd3, 4'b0101, 2'b00, 0, 0);
    add(1,0,0, 1, 3'd4, 4'b1001, 2'b00, 0, 0);  // sight held low -> TURN
    add(1,0,1, 2, 3'd4, 4'b1001, 2'b00, 0, 0);
    add(1,0,1, 1, 3'd2, 4'b0000, 2'b00, 0, 0);  // close -> STOP
    add(0,0,1, 1, 3'd5, 4'b0000, 2'b10, 0, 0);  // CLAW_DOWN, rasp dropped
    add(0,0,1, 9, 3'd5, 4'b0000, 2'b10, 0, 0);
    add(0,0,1, 1, 3'd6, 4'b0000, 2'b00, 1, 0);  // CLAW_CLOSE
    add(0,0,1, 9, 3'd6, 4'b0000, 2'b00, 1, 0);
    add(0,0,1, 1, 3'd7, 4'b0000, 2'b01, 1, 0);  // CLAW_UP
    add(0,0,1, 9, 3'd7, 4'b0000, 2'b01, 1, 0);
    add(0,0,1, 1, 3'd0, 4'b0000, 2'b00, 0, 1);  // released, one pick
    add(0,0,0, 9, 3'd0, 4'b0000, 2'b00, 0, 1);
    add(0,0,0, 1, 3'd1, 4'b0000, 2'b00, 0, 1);
    add(1,0,0, 3, 3'd2, 4'b0000, 2'b00, 0, 1);
    add(1,0,0, 1, 3'd4, 4'b1001, 2'b00, 0, 1);
    add(1,0,0,12, 3'd4, 4'b1001, 2'b00, 0, 1);  // one slice done
    add(0,0,0, 2, 3'd4, 4'b1001, 2'b00, 0, 1);
    add(0,0,0, 1, 3'd1, 4'b0000, 2'b00, 0, 1);  // rasp loss -> IDLE
    add(1,0,0, 3, 3'd2, 4'b0000, 2'b00, 0, 1);
    add(1,0,0, 1, 3'd4, 4'b1001, 2'b00, 0, 1);
    add(1,0,0,31, 3'd4, 4'b1001, 2'b00, 0, 1);  // turn count restarted from 0
    add(1,0,0, 1, 3'd3, 4'b0101, 2'b00, 0, 1);
    add(1,0,1, 2, 3'd3, 4'b0101, 2'b00, 0, 1);
    add(1,0,1, 1, 3'd2, 4'b0000, 2'b00, 0, 1);  // close in FORWARD -> STOP

    #12;
    chk("reset_state", st0, 0);
    chk("reset_w_motor", w0, 0);
    chk("reset_c_motor", cm0, 0);
    chk("reset_c_close", cc0, 0);
    chk("reset_pick_count", pk0, 0);
    chk("reset_search_fail", sf0, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      rasp_on = tbl[i].r; obj_in_sight = tbl[i].s; obj_is_close = tbl[i].c;
      step(tbl[i].steps);
      chk($sformatf("row%0d_state", i), st0, tbl[i].st);
      chk($sformatf("row%0d_w_motor", i), w0, tbl[i].w);
      chk($sformatf("row%0d_c_motor", i), cm0, tbl[i].cm);
      chk($sformatf("row%0d_c_close", i), cc0, tbl[i].cc);
      chk($sformatf("row%0d_pick_count", i), pk0, tbl[i].pk);
      chk($sformatf("row%0d_search_fail", i), sf0, 0);
    end

    // back-to-back picks: hold mode re-picks from STOP, counter saturates at 3
    rst = 1'b0;
    rasp_on = 1'b1; obj_in_sight = 1'b0; obj_is_close = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    step(42);
    chk("hold_state_pick1", st1, 2);
    chk("hold_c_close_pick1", cc1, 1);
    chk("hold_count_pick1", pk1, 1);
    chk("rel_state_pick1", st0, 0);
    chk("rel_c_close_pick1", cc0, 0);
    step(31);
    chk("hold_count_pick2", pk1, 2);
    step(31);
    chk("hold_count_pick3", pk1, 3);
    step(31);
    chk("hold_count_sat", pk1, 3);
    chk("hold_state_pick4", st1, 2);
    chk("hold_c_close_pick4", cc1, 1);
    chk("rel_count_pick3", pk0, 3);
    step(5);
    chk("hold_down_before_rst", cm1, 2);

    // asynchronous reset in the middle of CLAW_DOWN
    rst = 1'b0;
    #2;
    chk("midrst_state", st1, 0);
    chk("midrst_c_motor", cm1, 0);
    chk("midrst_c_close", cc1, 0);
    chk("midrst_count", pk1, 0);
    chk("midrst_count_d0", pk0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(9);
    chk("after_rst_open", st1, 0);
    step(1);
    chk("after_rst_idle", st1, 1);

`ifdef ROBINHO_SEARCH_TIMEOUT_EN
    // two consecutive escapes without sight -> IDLE with sticky search_fail
    rst = 1'b0;
    rasp_on = 1'b1; obj_in_sight = 1'b0; obj_is_close = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    step(83);
    chk("tmo_turn_before", st0, 4);
    chk("tmo_fail_before", sf0, 0);
    step(1);
    chk("tmo_idle", st0, 1);
    chk("tmo_fail_set", sf0, 1);
    step(5);
    chk("tmo_idle_held", st0, 1);
    chk("tmo_fail_sticky", sf0, 1);
    rasp_on = 1'b0;
    step(3);
    chk("tmo_fail_clear", sf0, 0);
    chk("tmo_idle_clear", st0, 1);
    rasp_on = 1'b1;
    step(3);
    chk("tmo_restart_stop", st0, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/robinho_ctrl_v2.md
Name: robinho_ctrl_v2

Overview:
- Second-generation pick-up robot controller. Sits between the Raspberry Pi sensor interface (rasp_on, obj_in_sight, obj_is_close) and the wheel/claw motor drivers.
- Searches for an object, approaches it, then runs a timed claw sequence: down, close, up, optional release.
- Generalised over the first version: all dwell times are parameters, inputs are synchronised, the turn limit is parameterised, release mode is selectable, and a pick counter is provided.

Parameters:
- TW, 24: timer width in bits; every T_* must be < 2^TW.
- T_CLAW_OPEN, 1000000: CLAW_OPEN dwell, in cycles.
- T_CLAW_DOWN, 1000000: CLAW_DOWN dwell, in cycles.
- T_CLAW_CLOSE, 1000000: CLAW_CLOSE dwell, in cycles.
- T_CLAW_UP, 1000000: CLAW_UP dwell, in cycles.
- T_STEP, 250000: length of one FORWARD or TURN slice, in cycles.
- MAX_TURNS, 4: TURN slices before a forced FORWARD escape (≥1).
- SYNC_STAGES, 2: synchroniser flops per sensor input (≥2).
- HOLD_AFTER_PICK, 0: 0 = release after lift; 1 = keep holding.
- PCW, 8: pick_count width.
- MAX_ESCAPES, 8: used only with the optional feature.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- rasp_on  input  1  Pi ready (async)
- obj_in_sight  input  1  object detected (async)
- obj_is_close  input  1  object within claw reach (async)
- w_motor  output  4  wheel drive
- c_motor  output  2  claw lift: [1]=down, [0]=up
- c_close  output  1  gripper closed
- state_o  output  3  current state code (debug)
- pick_count  output  PCW  completed picks, saturating
- search_fail  output  1  search timeout flag (optional feature)

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state = CLAW_OPEN, timer = 0, turn_cnt = 0, escape counter = 0, all sync flops = 0
  - w_motor = 0, c_motor = 0, c_close = 0, pick_count = 0, search_fail = 0
- Reset asserted mid-sequence aborts immediately; no state is remembered.
- Sensors are used only after SYNC_STAGES flops (signals *_s below). A pin change reaches *_s after SYNC_STAGES edges; the state reacts on the following edge.
- State codes: CLAW_OPEN=0, IDLE=1, STOP=2, FORWARD=3, TURN=4, CLAW_DOWN=5, CLAW_CLOSE=6, CLAW_UP=7.
- Timer: clears to 0 on every state entry (including a FORWARD/TURN slice restart) and increments each cycle, saturating. A timed state exits on the edge where timer == T−1, so dwell is exactly T cycles.
- Outputs are Moore-decoded from the state register:
  - FORWARD: w_motor = 4'b0101
  - TURN: w_motor = 4'b1001
  - CLAW_DOWN: c_motor = 2'b10
  - CLAW_UP: c_motor = 2'b01
  - all other cases: 0
- c_close is a register: set on entry to CLAW_CLOSE, cleared on entry to CLAW_OPEN, otherwise held.
- Transitions:
  - CLAW_OPEN: after T_CLAW_OPEN → IDLE.
  - IDLE: rasp_on_s → STOP.
  - STOP (single cycle), priority order: !rasp_on_s → IDLE; close_s → CLAW_DOWN; sight_s → FORWARD; else → TURN.
  - FORWARD, priority order:
    - !rasp_on_s → IDLE
    - close_s → STOP
    - slice end with sight_s → FORWARD (restart slice)
    - slice end with !sight_s → TURN, turn_cnt = 0
    - loss of sight mid-slice is ignored until slice end
  - TURN, priority order:
    - !rasp_on_s → IDLE
    - sight_s or close_s → STOP, turn_cnt = 0
    - slice end with turn_cnt == MAX_TURNS−1 → FORWARD (escape), turn_cnt = 0
    - slice end otherwise → TURN, turn_cnt + 1
  - CLAW_DOWN: after T_CLAW_DOWN → CLAW_CLOSE.
  - CLAW_CLOSE: after T_CLAW_CLOSE → CLAW_UP.
  - CLAW_UP: after T_CLAW_UP, pick_count + 1 (saturating at 2^PCW−1); then → CLAW_OPEN if HOLD_AFTER_PICK = 0, → STOP if 1.
- The claw sequence ignores rasp_on and all sensors; a pick always completes.
- IDLE entry from any state clears turn_cnt.

Optional Feature:
- Macro: ROBINHO_SEARCH_TIMEOUT_EN.
- Enabled:
  - Count consecutive escapes (TURN→FORWARD at the turn limit); the count clears on any sight_s- or close_s-driven exit.
  - Reaching MAX_ESCAPES → IDLE and search_fail = 1.
  - search_fail is sticky until rasp_on_s = 0 is seen in IDLE. While it is 1, IDLE does not advance.
- Disabled: no escape counter; search_fail is tied to 0.

Test Plan:
All tests use T_CLAW_*=10, T_STEP=8, MAX_TURNS=4, SYNC_STAGES=2.
- Release rst, all inputs 0 → CLAW_OPEN for 10 cycles, then IDLE, then outputs all 0; raise rasp_on → STOP 3 cycles later.
- rasp_on=1, sight=0 → TURN with w_motor=1001; after 4 slices (32 cycles) → FORWARD with w_motor=0101.
- In FORWARD, pulse sight low for 3 cycles mid-slice → still FORWARD at slice end; hold low → TURN.
- close=1 → STOP, then CLAW_DOWN 10 cycles with c_motor=10, then CLAW_CLOSE with c_close=1, then CLAW_UP with c_motor=01 → CLAW_OPEN with c_close=0 and pick_count=1; drop rasp_on during CLAW_DOWN → sequence still completes.
- HOLD_AFTER_PICK=1 → after CLAW_UP, STOP with c_close held at 1; with PCW=2, 4 picks → pick_count stays 3.
- Macro on, MAX_ESCAPES=2, sight=0 → after 2 escapes → IDLE, search_fail=1; rasp_on 0 then 1 → search_fail=0, STOP.
